// File: rtl/prog_sequencer_if.sv
// Fetch-side bundle between the program sequencer and the core/LUT.
// master: sequencer view (drives PC, ProgState, LutAddr, status).
// slave: core/bench view (drives Start, Halt, branch and LUT inputs).
interface prog_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             Start;
    logic             Halt;
    logic             BranchEn;
    logic [2:0]       BranchAddr;
    logic [7:0]       LutTarget;
    logic [7:0]       PC;
    logic [1:0]       ProgState;
    logic [2:0]       LutAddr;
    logic             Running;
    logic             Done;
    logic             Timeout;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        input  Start, Halt, BranchEn,
        input  BranchAddr, LutTarget,
        output PC, ProgState, LutAddr,
        output Running, Done, Timeout,
        output CycleCount
    );

    modport slave (
        output Start, Halt, BranchEn,
        output BranchAddr, LutTarget,
        input  PC, ProgState, LutAddr,
        input  Running, Done, Timeout,
        input  CycleCount
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program-level fetch controller: owns PC and ProgState, runs one
// program per Start, loads LUT targets on branches, counts cycles.
// Ports: Clk, Reset (sync, active-high), bus (master modport):
//   in  Start/Halt/BranchEn/BranchAddr/LutTarget
//   out PC/ProgState/LutAddr/Running/Done/Timeout/CycleCount
module prog_sequencer #(
    parameter int               NUM_PROGS  = 3,
    parameter logic [7:0]       PROG0_BASE = 8'd0,
    parameter logic [7:0]       PROG1_BASE = 8'd64,
    parameter logic [7:0]       PROG2_BASE = 8'd128,
    parameter logic [7:0]       PROG3_BASE = 8'd192,
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 16'd60000
) (
    input logic                Clk,
    input logic                Reset,
    prog_sequencer_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_PTR = 2'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] WD_LAST = MAX_CYCLES - CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [1:0]       ps_q, ps_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [7:0]       base;

    always_comb begin
        base = PROG0_BASE;
        case (ptr_q)
            2'd0:    base = PROG0_BASE;
            2'd1:    base = PROG1_BASE;
            2'd2:    base = PROG2_BASE;
            default: base = PROG3_BASE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ps_d    = ps_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    state_d = RUN;
                    ps_d    = ptr_q;
                    pc_d    = base;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    ptr_d   = (ptr_q == LAST_PTR) ? 2'd0
                                                  : ptr_q + 2'd1;
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Halt beats watchdog beats branch beats fall-through.
                priority case (1'b1)
                    bus.Halt: begin
                        state_d = DONE;
                        to_d    = 1'b0;
                    end
                    (cnt_q == WD_LAST): begin
                        state_d = DONE;
                        to_d    = 1'b1;
                    end
                    bus.BranchEn: pc_d = bus.LutTarget;
                    default:      pc_d = pc_q + 8'd1;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ps_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ps_q    <= ps_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.ProgState  = ps_q;
    assign bus.LutAddr    = bus.BranchAddr;
    assign bus.Running    = (state_q == RUN);
    assign bus.Done       = (state_q == DONE);
    assign bus.Timeout    = to_q;
    assign bus.CycleCount = cnt_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: table of per-cycle vectors on a default
// instance, plus a watchdog sequence on a MAX_CYCLES=10 instance.
module tb_prog_sequencer;
    logic Clk;
    logic Reset;
    logic WReset;
    int   n_cmp;
    int   n_bad;

    prog_sequencer_if #(.CNT_W(16)) bus ();
    prog_sequencer_if #(.CNT_W(16)) wbus ();

    prog_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    prog_sequencer #(.MAX_CYCLES(16'd10)) wdut (
        .Clk   (Clk),
        .Reset (WReset),
        .bus   (wbus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic        h;
        logic        br;
        logic [2:0]  ba;
        logic [7:0]  lut;
        logic [7:0]  pc;
        logic [1:0]  ps;
        logic        run;
        logic        done;
        logic        to;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic st, input logic h,
        input logic br, input logic [2:0] ba,
        input logic [7:0] lut, input logic [7:0] pc,
        input logic [1:0] ps, input logic run,
        input logic done, input logic to,
        input logic [15:0] cnt);
        vec_t v;
        v = '{rst, st, h, br, ba, lut, pc, ps, run, done, to, cnt};
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, want %0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic chk_out(input int idx,
                           input logic [7:0] pc,
                           input logic [1:0] ps,
                           input logic run, input logic done,
                           input logic to,
                           input logic [15:0] cnt);
        chk("PC", idx, 32'(bus.PC), 32'(pc));
        chk("ProgState", idx, 32'(bus.ProgState), 32'(ps));
        chk("Running", idx, 32'(bus.Running), 32'(run));
        chk("Done", idx, 32'(bus.Done), 32'(done));
        chk("Timeout", idx, 32'(bus.Timeout), 32'(to));
        chk("CycleCount", idx, 32'(bus.CycleCount), 32'(cnt));
    endtask

    task automatic wchk(input int idx,
                        input logic [7:0] pc,
                        input logic [1:0] ps,
                        input logic run, input logic done,
                        input logic to,
                        input logic [15:0] cnt);
        chk("wd PC", idx, 32'(wbus.PC), 32'(pc));
        chk("wd ProgState", idx, 32'(wbus.ProgState), 32'(ps));
        chk("wd Running", idx, 32'(wbus.Running), 32'(run));
        chk("wd Done", idx, 32'(wbus.Done), 32'(done));
        chk("wd Timeout", idx, 32'(wbus.Timeout), 32'(to));
        chk("wd CycleCount", idx, 32'(wbus.CycleCount), 32'(cnt));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b1;
        WReset = 1'b1;
        bus.Start = 0; bus.Halt = 0; bus.BranchEn = 0;
        bus.BranchAddr = '0; bus.LutTarget = '0;
        wbus.Start = 0; wbus.Halt = 0; wbus.BranchEn = 0;
        wbus.BranchAddr = '0; wbus.LutTarget = '0;

        //       rst st h br ba lut     pc     ps r d t cnt
        // program 0: halt in 5th RUN cycle
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h00,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h01,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h02,0,1,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h03,0,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h04,0,1,0,0,4));
        tbl.push_back(mk(0,0,1,0,0,8'h00, 8'h04,0,0,1,0,5));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h04,0,0,1,0,5));
        // program 1: branch at 0x42, Start in RUN ignored
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h40,1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h41,1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h42,1,1,0,0,2));
        tbl.push_back(mk(0,1,0,1,3,8'h5A, 8'h5A,1,1,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h5B,1,1,0,0,4));
        // halt and branch together: halt wins, PC holds
        tbl.push_back(mk(0,0,1,1,5,8'h10, 8'h5B,1,0,1,0,5));
        // program 2, then wrap back to program 0
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h80,2,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00, 8'h80,2,0,1,0,1));
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h00,0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00, 8'h00,0,0,1,0,1));
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h40,1,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,8'h00, 8'h40,1,0,1,0,1));
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h80,2,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h81,2,1,0,0,1));
        // reset mid-RUN on program 2, idle holds, restart at 0
        tbl.push_back(mk(1,0,0,0,0,8'h00, 8'h00,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h00,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,8'h00, 8'h00,0,1,0,0,0));
        // branch to 0xFF then sequential wrap to 0x00
        tbl.push_back(mk(0,0,0,1,7,8'hFF, 8'hFF,0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,8'h00, 8'h00,0,1,0,0,2));
        tbl.push_back(mk(0,0,1,0,0,8'h00, 8'h00,0,0,1,0,3));

        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk_out(-1, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            Reset          = tbl[i].rst;
            bus.Start      = tbl[i].st;
            bus.Halt       = tbl[i].h;
            bus.BranchEn   = tbl[i].br;
            bus.BranchAddr = tbl[i].ba;
            bus.LutTarget  = tbl[i].lut;
            #1;
            chk("LutAddr", i, 32'(bus.LutAddr), 32'(tbl[i].ba));
            @(posedge Clk);
            #1;
            chk_out(i, tbl[i].pc, tbl[i].ps, tbl[i].run,
                    tbl[i].done, tbl[i].to, tbl[i].cnt);
        end
        Reset = 1'b0;
        bus.Start = 0; bus.Halt = 0; bus.BranchEn = 0;

        // watchdog instance: 10 RUN cycles, no halt
        WReset = 1'b0;
        wchk(100, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        wbus.Start = 1'b1;
        @(posedge Clk);
        #1;
        wbus.Start = 1'b0;
        wchk(101, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge Clk);
            #1;
            wchk(101 + k, 8'(k), 2'd0, 1'b1, 1'b0, 1'b0, 16'(k));
        end
        @(posedge Clk);
        #1;
        wchk(111, 8'h09, 2'd0, 1'b0, 1'b1, 1'b1, 16'd10);
        @(posedge Clk);
        #1;
        wchk(112, 8'h09, 2'd0, 1'b0, 1'b1, 1'b1, 16'd10);
        wbus.Start = 1'b1;
        @(posedge Clk);
        #1;
        wbus.Start = 1'b0;
        wchk(113, 8'h40, 2'd1, 1'b1, 1'b0, 1'b0, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
